// File: rtl/procik_pkg.sv
// Shared definitions for the procik datapath: opcodes, execute-stage FSM states
// and flag bit positions within the {Z, Nf, C, V} flag word.
package procik_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_FIN  = 2'd3
    } alu_state_t;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_exec_if.sv
// Control-unit <-> execute-stage bus. Operands/results use bit 0 as the MSB.
// dbg_state exposes the execute FSM for observation.
interface alu_exec_if #(parameter int N = 16);
    import procik_pkg::*;

    // Handshake: the master raises start with op/a/b valid; the stage samples them
    // only while idle. busy is high from the cycle after acceptance until done;
    // done is a one-cycle pulse marking result/flags/illegal valid, and a new
    // start presented during that done cycle is accepted on the next edge.
    logic           start;
    logic [2:0]     op;
    logic [0:N-1]   a;
    logic [0:N-1]   b;
    logic           busy;
    logic           done;
    logic [0:N-1]   result;
    logic [3:0]     flags;
    logic           illegal;
    alu_state_t     dbg_state;

    modport master (
        output start, op, a, b,
        input  busy, done, result, flags, illegal, dbg_state
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, flags, illegal, dbg_state
    );

endinterface

// File: rtl/mul_shift_add.sv
// Iterative unsigned N x N multiplier, one shift-add step per 'step' cycle.
// Compiled only when ALU_MUL_EN is defined.
`ifdef ALU_MUL_EN
module mul_shift_add #(parameter int N = 16) (
    input  logic           clock,
    input  logic           reset,
    input  logic           load,
    input  logic           step,
    input  logic [0:N-1]   a,
    input  logic [0:N-1]   b,
    output logic [0:2*N-1] product
);

    logic [N-1:0]   mcand;
    logic [2*N-1:0] acc;
    logic [N:0]     sum;

    // Upper half accumulates the multiplicand whenever the current multiplier
    // bit (acc LSB) is set; the whole register then shifts right by one.
    assign sum = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, mcand} : '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mcand <= '0;
            acc   <= '0;
        end else if (load) begin
            mcand <= a;
            acc   <= {{N{1'b0}}, b};
        end else if (step) begin
            acc   <= {sum, acc[N-1:1]};
        end
    end

    assign product = acc;

endmodule
`endif

// File: rtl/alu_exec.sv
// Execute stage: one ALU operation per accepted start, registered result/flags.
// ALU_MUL_EN compiles in the iterative multiplier; otherwise op 7 is illegal.
module alu_exec #(parameter int N = 16) (
    input  logic clock,
    input  logic reset,
    alu_exec_if.slave bus
);
    import procik_pkg::*;

    alu_state_t   state;
    logic [2:0]   op_q;
    logic [0:N-1] a_q;
    logic [0:N-1] b_q;

    logic [N:0]   sum_ext;
    logic [0:N-1] exec_res;
    logic         exec_c;
    logic         exec_v;
    logic         exec_illegal;
    logic [3:0]   exec_flags;

    always_comb begin
        sum_ext      = '0;
        exec_res     = '0;
        exec_c       = 1'b0;
        exec_v       = 1'b0;
        exec_illegal = 1'b0;
        exec_flags   = '0;
        case (op_q)
            OP_ADD: begin
                sum_ext  = {1'b0, a_q} + {1'b0, b_q};
                exec_res = sum_ext[N-1:0];
                exec_c   = sum_ext[N];
                exec_v   = (a_q[0] == b_q[0]) && (exec_res[0] != a_q[0]);
            end
            OP_SUB: begin
                sum_ext  = {1'b0, a_q} - {1'b0, b_q};
                exec_res = sum_ext[N-1:0];
                exec_c   = (a_q < b_q);
                exec_v   = (a_q[0] != b_q[0]) && (exec_res[0] != a_q[0]);
            end
            OP_AND: exec_res = a_q & b_q;
            OP_OR:  exec_res = a_q | b_q;
            OP_XOR: exec_res = a_q ^ b_q;
            OP_SHL: begin
                exec_res = a_q << 1;
                exec_c   = a_q[0];
            end
            OP_SHR: begin
                exec_res = a_q >> 1;
                exec_c   = a_q[N-1];
            end
            // Only reachable for op 7 when the multiplier is not built.
            default: exec_illegal = 1'b1;
        endcase
        exec_flags[FLAG_Z] = (exec_res == '0);
        exec_flags[FLAG_N] = exec_res[0];
        exec_flags[FLAG_C] = exec_c;
        exec_flags[FLAG_V] = exec_v;
    end

`ifdef ALU_MUL_EN
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic [CW-1:0]  cnt;
    logic [0:2*N-1] product;
    logic [0:N-1]   mul_lo;
    logic [3:0]     mul_flags;
    logic           mul_load;

    assign mul_load = (state == S_IDLE) && bus.start && (bus.op == OP_MUL);
    assign mul_lo   = product[N:2*N-1];

    always_comb begin
        mul_flags         = '0;
        mul_flags[FLAG_Z] = (mul_lo == '0);
        mul_flags[FLAG_N] = mul_lo[0];
        mul_flags[FLAG_C] = |product[0:N-1];
    end

    mul_shift_add #(.N(N)) u_mul (
        .clock   (clock),
        .reset   (reset),
        .load    (mul_load),
        .step    (state == S_MUL),
        .a       (bus.a),
        .b       (bus.b),
        .product (product)
    );
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.result  <= '0;
            bus.flags   <= '0;
            bus.illegal <= 1'b0;
`ifdef ALU_MUL_EN
            cnt         <= '0;
`endif
        end else begin
            bus.done    <= 1'b0;
            bus.illegal <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        op_q     <= bus.op;
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        bus.busy <= 1'b1;
`ifdef ALU_MUL_EN
                        cnt      <= '0;
                        state    <= (bus.op == OP_MUL) ? S_MUL : S_EXEC;
`else
                        state    <= S_EXEC;
`endif
                    end
                end
                S_EXEC: begin
                    bus.busy    <= 1'b0;
                    bus.done    <= 1'b1;
                    bus.illegal <= exec_illegal;
                    bus.result  <= exec_res;
                    // An illegal opcode leaves the previous flags in place.
                    if (!exec_illegal) bus.flags <= exec_flags;
                    state       <= S_IDLE;
                end
`ifdef ALU_MUL_EN
                S_MUL: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) state <= S_FIN;
                end
                S_FIN: begin
                    bus.busy   <= 1'b0;
                    bus.done   <= 1'b1;
                    bus.result <= mul_lo;
                    bus.flags  <= mul_flags;
                    state      <= S_IDLE;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.dbg_state = state;

endmodule

// File: doc/alu_exec.md
# alu_exec

Execute stage of the procik datapath. It consumes the operand read out of the GPR file through the GPR read mux, plus a second operand and an opcode supplied by the control unit. It performs one arithmetic or logic operation per `start` pulse and returns a registered result and flags. The control unit writes that result back over the data bus. Single-cycle ops finish in one clock; multiply is an iterative multi-cycle operation, so the block runs a start/busy/done handshake.

## Interface
- `N`, default 16: operand and result width. Bit 0 is the MSB, consistent with the datapath.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: request; sampled only in IDLE.
- `op` in 3: opcode, sampled with `start`.
- `a` in N: operand A, sampled with `start`.
- `b` in N: operand B, sampled with `start`.
- `busy` out 1: high from the cycle after accepted `start` until `done`.
- `done` out 1: one-cycle completion pulse.
- `result` out N: registered result; holds until the next completion.
- `flags` out 4: {Z, Nf, C, V}, registered and updated only on `done`.
- `illegal` out 1: pulses with `done` when the opcode is unsupported.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical), 7 MUL.
- States:
  - IDLE: accepts `start` and latches `op`, `a`, `b`.
    - Goes to EXEC for ops 0–6.
    - Goes to MUL for op 7.
  - EXEC: computes the result, asserts `done`, returns to IDLE.
  - MUL: one shift-add step per cycle for N cycles, then goes to FIN.
  - FIN: asserts `done`, returns to IDLE.
- Arithmetic and flags:
  - ADD: {C, result} = a + b. V = signed overflow.
  - SUB: result = a − b mod 2^N. C = borrow (a < b unsigned). V = signed overflow.
  - AND/OR/XOR: C = 0, V = 0.
  - SHL: result = a << 1. C = old MSB. V = 0.
  - SHR: result = a >> 1, zero-filled. C = old LSB. V = 0.
  - MUL: unsigned. result = low N bits of the product. C = 1 if the high N bits are nonzero. V = 0.
  - All ops: Z = (result == 0). Nf = result MSB.
  - `b` is ignored for SHL and SHR.
- `start` while busy (EXEC/MUL/FIN) is ignored; there is no queuing.
- `start` is accepted in the same cycle `done` is high: the FSM is in IDLE again on the following edge.
- Reset in any state, including mid-MUL, returns to IDLE with all outputs and internal registers zero.

## Timing
- Reset values:
  - `busy` = 0
  - `done` = 0
  - `result` = 0
  - `flags` = 4'b0000
  - `illegal` = 0
- Single-cycle ops: `start` sampled at edge t.
  - `busy` = 1 during cycle t+1.
  - `done`, `result` and `flags` are valid after edge t+1.
- MUL: `start` at edge t, then N MUL cycles, then FIN.
  - `done` after edge t+N+1; latency N+1 = 17 cycles at N=16.
  - `busy` stays high throughout.
- `done` is exactly one cycle wide; `busy` deasserts in the cycle `done` is high.
- Operands may change after the accept edge; latched copies are used.

## Configuration
- `ALU_MUL_EN` defined: MUL state and multiplier sub-module are compiled in, behaving as above.
- `ALU_MUL_EN` undefined: op 7 is unsupported.
  - It takes the EXEC path with one-cycle latency.
  - `done` and `illegal` both pulse.
  - `result` is forced to 0; `flags` are left unchanged.
  - No multiplier logic is synthesized.

## Structure
- Shared package `procik_pkg` holds:
  - Opcode constants (`OP_ADD` … `OP_MUL`).
  - FSM state encoding (IDLE, EXEC, MUL, FIN).
  - Flag bit indices (`FLAG_Z`, `FLAG_N`, `FLAG_C`, `FLAG_V`).
- Sub-module `mul_shift_add` is the iterative N-step unsigned multiplier: load/step inputs, 2N-bit product output, wrapped in the `ALU_MUL_EN` guard.
- Top-level `alu_exec` holds the FSM, latched operands, single-cycle datapath and output registers.

## Test plan
- Reset: assert `reset` mid-MUL (cycle 5) → `busy`=0, `result`=0, `flags`=0 immediately; the next `start` ADD 1+1 gives `result`=2 after 1 cycle.
- ADD wrap: `a`=16'hFFFF, `b`=16'h0001 → `result`=0, Z=1, C=1, V=0, `done` after 1 cycle.
- SUB overflow: `a`=16'h8000, `b`=16'h0001 → `result`=16'h7FFF, V=1, C=0, Nf=0.
- Shifts: SHL of 16'h8001 → 16'h0002, C=1; SHR of 16'h0001 → 0, Z=1, C=1.
- MUL: 16'h0100 × 16'h0100 → `result`=0, C=1, `done` exactly 17 cycles after `start`; a second `start` during `busy` is ignored.
- With `ALU_MUL_EN` undefined: op 7 → `done` and `illegal` pulse after 1 cycle, `result`=0, `flags` unchanged from the previous op.
